// File: rtl/std_fp_mult_seq.sv
// Sequential radix-2 shift-and-add unsigned fixed-point multiplier.
// It retires one multiplier bit per cycle and uses a go/done handshake.
module std_fp_mult_seq #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    generate
        if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_params
            $error("std_fp_mult_seq: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN: begin
                if (!go)
                    state_d = IDLE;
                else if (last_step)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final addition is folded into the captured result so no extra cycle is needed.
    always_comb begin
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, left};
                    mplier_d = right;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (go) begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_step)
                        out_d = acc_sum[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        done = (state_q == DONE);
    end

    assign out = out_q;

endmodule
